// File: rtl/alu_exec_unit.sv
// EX-stage ALU with valid/ready on both sides; single-cycle logic/arith ops and an
// iterative shift-add multiply. Define ALU_EXEC_SLT_EN to add set-less-than (funct 101010, ALUOp 11).
module alu_exec_unit #(
   parameter int WIDTH = 32,
   parameter int CNT_W = $clog2(WIDTH) + 1
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             valid_i,
   output logic             ready_o,
   input  logic [1:0]       ALUOp_i,
   input  logic [5:0]       funct_i,
   input  logic [WIDTH-1:0] data1_i,
   input  logic [WIDTH-1:0] data2_i,
   output logic             valid_o,
   input  logic             ready_i,
   output logic [WIDTH-1:0] data_o,
   output logic             zero_o,
   output logic             ovf_o,
   output logic             err_o
);
   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_MUL  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   localparam logic [2:0] OP_ADD = 3'd0;
   localparam logic [2:0] OP_SUB = 3'd1;
   localparam logic [2:0] OP_AND = 3'd2;
   localparam logic [2:0] OP_OR  = 3'd3;
   localparam logic [2:0] OP_MUL = 3'd4;
   localparam logic [2:0] OP_SLT = 3'd5;
   localparam logic [2:0] OP_ERR = 3'd6;

   localparam int MSB = WIDTH - 1;

   logic [1:0]       state;
   logic [WIDTH-1:0] acc, mcand, mplier;
   logic [CNT_W-1:0] cnt;

   logic [2:0]       op;
   logic [WIDTH-1:0] sum, diff, res, acc_nxt;
   logic             ovf, err;

   always_comb begin
      op = OP_ERR;
      case (ALUOp_i)
         2'b00: op = OP_ADD;
         2'b01: op = OP_SUB;
         2'b10: begin
            case (funct_i)
               6'b100100: op = OP_AND;
               6'b100101: op = OP_OR;
               6'b100000: op = OP_ADD;
               6'b100010: op = OP_SUB;
               6'b011000: op = OP_MUL;
`ifdef ALU_EXEC_SLT_EN
               6'b101010: op = OP_SLT;
`endif
               default:   op = OP_ERR;
            endcase
         end
         default: begin
`ifdef ALU_EXEC_SLT_EN
            op = OP_SLT;
`else
            op = OP_ERR;
`endif
         end
      endcase
   end

   assign sum  = data1_i + data2_i;
   assign diff = data1_i - data2_i;

   // Overflow: result sign flips away from A when the effective operand signs agree.
   always_comb begin
      res = '0;
      ovf = 1'b0;
      err = 1'b0;
      case (op)
         OP_ADD: begin
            res = sum;
            ovf = (data1_i[MSB] == data2_i[MSB]) && (sum[MSB] != data1_i[MSB]);
         end
         OP_SUB: begin
            res = diff;
            ovf = (data1_i[MSB] != data2_i[MSB]) && (diff[MSB] != data1_i[MSB]);
         end
         OP_AND: res = data1_i & data2_i;
         OP_OR:  res = data1_i | data2_i;
         OP_SLT: res = {{(WIDTH-1){1'b0}}, ($signed(data1_i) < $signed(data2_i))};
         default: err = 1'b1;
      endcase
   end

   assign acc_nxt = acc + (mplier[0] ? mcand : '0);

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state  <= S_IDLE;
         acc    <= '0;
         mcand  <= '0;
         mplier <= '0;
         cnt    <= '0;
         data_o <= '0;
         zero_o <= 1'b0;
         ovf_o  <= 1'b0;
         err_o  <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (valid_i) begin
                  if (op == OP_MUL) begin
                     state  <= S_MUL;
                     acc    <= '0;
                     mcand  <= data1_i;
                     mplier <= data2_i;
                     cnt    <= '0;
                  end else begin
                     state  <= S_DONE;
                     data_o <= res;
                     zero_o <= (res == '0);
                     ovf_o  <= ovf;
                     err_o  <= err;
                  end
               end
            end
            S_MUL: begin
               acc    <= acc_nxt;
               mcand  <= mcand << 1;
               mplier <= mplier >> 1;
               cnt    <= cnt + CNT_W'(1);
               // Last iteration writes the result directly so DONE follows without a spare cycle.
               if (cnt == CNT_W'(WIDTH - 1)) begin
                  state  <= S_DONE;
                  data_o <= acc_nxt;
                  zero_o <= (acc_nxt == '0);
                  ovf_o  <= 1'b0;
                  err_o  <= 1'b0;
               end
            end
            S_DONE: begin
               if (ready_i) state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   assign ready_o = (state == S_IDLE);
   assign valid_o = (state == S_DONE);

endmodule
